// File: rtl/b10_pkg.sv
// Shared definitions for the b10 voting-terminal controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package b10_pkg;

    localparam int VWIDTH = 4;

    // Controller states; encoding values are architecturally visible.
    typedef enum logic [3:0] {
        STARTUP  = 4'd0,
        STANDBY  = 4'd1,
        GET_IN   = 4'd2,
        START_TX = 4'd3,
        SEND     = 4'd4,
        TX_2_RX  = 4'd5,
        RECEIVE  = 4'd6,
        RX_2_TX  = 4'd7,
        TEST     = 4'd8
    } state_t;

    // Outgoing word: vote bits {voto3..voto0} masked with the session sign.
    function automatic logic [VWIDTH-1:0] encode_vote(
        input logic [VWIDTH-1:0] voto,
        input logic [VWIDTH-1:0] sign
    );
        return voto ^ sign;
    endfunction

endpackage

// File: rtl/b10_voting_if.sv
// Serial-link side of the voting terminal: vote transmit (rtr/cts) and sign receive (rts/ctr).
// Latency: n/a (wiring only).
// Backpressure: four-phase level handshakes, no timeouts.
//
// Signals:
//   rtr   remote ready-to-receive           (link -> controller)
//   cts   clear-to-send acknowledge          (controller -> link)
//   rts   remote request-to-send            (link -> controller)
//   ctr   clear-to-receive acknowledge       (controller -> link)
//   v_in  incoming sign / test data word     (link -> controller)
//   v_out outgoing encoded vote word         (controller -> link)
interface b10_voting_if;
    import b10_pkg::*;

    logic              rtr;
    logic              cts;
    logic              rts;
    logic              ctr;
    logic [VWIDTH-1:0] v_in;
    logic [VWIDTH-1:0] v_out;

    // Controller side.
    modport master (
        input  rtr, rts, v_in,
        output cts, ctr, v_out
    );

    // Remote link side.
    modport slave (
        output rtr, rts, v_in,
        input  cts, ctr, v_out
    );

endinterface

// File: rtl/b10_voting.sv
// Voting-terminal controller: collects a vote, sends it sign-masked, then receives a new sign.
// Latency: one clock from a request level change to the acknowledge change; all outputs registered.
// Backpressure: waits indefinitely on rtr (send) and rts (receive); no timeouts.
//
// Ports:
//   clock     rising-edge system clock
//   reset     synchronous active-low reset
//   r_button  red button level (rising edge toggles vote bit 2 in GET_IN)
//   g_button  green button level (rising edge toggles vote bit 1 in GET_IN)
//   key       voter key present
//   start     vote session enable
//   test      test-mode request, sampled in STARTUP/TEST
//   __obs     observation strobe, no functional effect
//   link      serial-link handshake bundle (master side)
module b10_voting
    import b10_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    input  logic          r_button,
    input  logic          g_button,
    input  logic          key,
    input  logic          start,
    input  logic          test,
    input  logic          __obs,
    b10_voting_if.master  link
);

    state_t            state;
    logic [VWIDTH-1:0] voto;      // {voto3 parity, voto2 red, voto1 green, voto0 key}
    logic [VWIDTH-1:0] sign;
    logic              last_g;
    logic              last_r;
    logic              cts_q;
    logic              ctr_q;
    logic [VWIDTH-1:0] v_out_q;

    // The observation strobe is deliberately left without any functional effect.
    logic unused_obs;
    assign unused_obs = __obs;

    assign link.cts   = cts_q;
    assign link.ctr   = ctr_q;
    assign link.v_out = v_out_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= STARTUP;
            voto    <= '0;
            sign    <= '0;
            last_g  <= 1'b0;
            last_r  <= 1'b0;
            cts_q   <= 1'b0;
            ctr_q   <= 1'b0;
            v_out_q <= '0;
        end else begin
            case (state)
                STARTUP: begin
                    voto  <= '0;
                    cts_q <= 1'b0;
                    ctr_q <= 1'b0;
                    if (test) begin
                        state <= TEST;
                    end else begin
                        sign  <= '0;
                        state <= STANDBY;
                    end
                end

                TEST: begin
                    // Test data doubles as the session sign.
                    v_out_q <= link.v_in;
                    sign    <= link.v_in;
                    if (!test) state <= STANDBY;
                end

                STANDBY: begin
                    cts_q <= link.rtr;
                    if (start) begin
                        voto   <= '0;
                        // Seed edge detectors so a button already held does not count.
                        last_g <= g_button;
                        last_r <= r_button;
                        state  <= GET_IN;
                    end
                end

                GET_IN: begin
                    if (!start) begin
                        state <= START_TX;
                    end else if (key) begin
                        voto[0] <= 1'b1;
                        if (g_button && !last_g) voto[1] <= ~voto[1];
                        if (r_button && !last_r) voto[2] <= ~voto[2];
                    end else begin
                        // Key removed: discard the vote in progress.
                        voto[2:0] <= '0;
                    end
                    last_g <= g_button;
                    last_r <= r_button;
                end

                START_TX: begin
                    voto[3] <= voto[1] ^ voto[2];
                    state   <= SEND;
                end

                SEND: begin
                    if (link.rtr) begin
                        v_out_q <= encode_vote(voto, sign);
                        cts_q   <= 1'b1;
                        state   <= TX_2_RX;
                    end
                end

                TX_2_RX: begin
                    if (!link.rtr) begin
                        cts_q <= 1'b0;
                        state <= RECEIVE;
                    end
                end

                RECEIVE: begin
                    if (link.rts) begin
                        sign  <= link.v_in;
                        ctr_q <= 1'b1;
                        state <= RX_2_TX;
                    end
                end

                RX_2_TX: begin
                    if (!link.rts) begin
                        ctr_q <= 1'b0;
                        state <= STANDBY;
                    end
                end

                default: begin
                    state   <= STARTUP;
                    cts_q   <= 1'b0;
                    ctr_q   <= 1'b0;
                    v_out_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_b10_voting.sv
// Directed self-checking bench for b10_voting.
// Latency: n/a.
// Backpressure: n/a.
module tb_b10_voting;
    import b10_pkg::*;

    logic clock = 1'b0;
    logic reset, r_button, g_button, key, start, test, obs;

    int n_vec = 0;
    int n_err = 0;

    b10_voting_if link ();

    b10_voting dut (
        .clock    (clock),
        .reset    (reset),
        .r_button (r_button),
        .g_button (g_button),
        .key      (key),
        .start    (start),
        .test     (test),
        .__obs    (obs),
        .link     (link.master)
    );

    always #5 clock = ~clock;

    // Advance one active edge and settle; inputs are driven and outputs sampled here.
    task automatic tick();
        @(posedge clock);
        #1;
        obs = ~obs;
    endtask

    task automatic check_outs(input string name, input logic [3:0] v_exp,
                              input logic cts_exp, input logic ctr_exp);
        n_vec++;
        if (link.v_out !== v_exp || link.cts !== cts_exp || link.ctr !== ctr_exp) begin
            n_err++;
            $display("FAIL %s: v_out=%b cts=%b ctr=%b, required v_out=%b cts=%b ctr=%b",
                     name, link.v_out, link.cts, link.ctr, v_exp, cts_exp, ctr_exp);
        end
    endtask

    // Runs a full vote from STANDBY up to SEND with optional green/red button edges.
    task automatic run_vote(input logic g_pulse, input logic r_pulse);
        g_button = 1'b0; r_button = 1'b0; key = 1'b0;
        start = 1'b1;            tick();  // STANDBY -> GET_IN
        key = 1'b1;              tick();  // voto0 = 1
        g_button = g_pulse;
        r_button = r_pulse;      tick();  // edges toggle
        tick();                           // held levels: no further toggle
        start = 1'b0;            tick();  // -> START_TX
        tick();                           // parity, -> SEND
        g_button = 1'b0; r_button = 1'b0; key = 1'b0;
    endtask

    // From SEND: complete transmit with given expectation, then load a new sign.
    task automatic send_and_receive(input string name, input logic [3:0] v_exp,
                                    input logic [3:0] new_sign);
        link.rtr = 1'b1;         tick();
        check_outs({name, "_send"}, v_exp, 1'b1, 1'b0);
        link.rtr = 1'b0;         tick();
        check_outs({name, "_cts_drop"}, v_exp, 1'b0, 1'b0);
        link.v_in = new_sign;
        link.rts  = 1'b1;        tick();
        check_outs({name, "_ctr"}, v_exp, 1'b0, 1'b1);
        link.rts  = 1'b0;        tick();
        check_outs({name, "_ctr_drop"}, v_exp, 1'b0, 1'b0);
        n_vec++;
        if (dut.state !== STANDBY) begin
            n_err++;
            $display("FAIL %s_standby: state=%0d, required %0d", name, dut.state, STANDBY);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; test = 1'b0; start = 1'b0; key = 1'b0;
        g_button = 1'b0; r_button = 1'b0; obs = 1'b0;
        link.rtr = 1'b0; link.rts = 1'b0; link.v_in = 4'b0000;
        tick(); tick();
        check_outs("reset_outs", 4'b0000, 1'b0, 1'b0);
        n_vec++;
        if (dut.state !== STARTUP) begin
            n_err++;
            $display("FAIL reset_state: state=%0d, required %0d", dut.state, STARTUP);
        end
        reset = 1'b1;            tick();
        n_vec++;
        if (dut.state !== STANDBY) begin
            n_err++;
            $display("FAIL startup_to_standby: state=%0d, required %0d", dut.state, STANDBY);
        end
        check_outs("standby_outs", 4'b0000, 1'b0, 1'b0);
    endtask

    task automatic test_cts_mirror();
        link.rtr = 1'b1;         tick();
        check_outs("mirror_hi", 4'b0000, 1'b1, 1'b0);
        link.rtr = 1'b0;         tick();
        check_outs("mirror_lo", 4'b0000, 1'b0, 1'b0);
        n_vec++;
        if (dut.state !== STANDBY) begin
            n_err++;
            $display("FAIL mirror_state: state=%0d, required %0d", dut.state, STANDBY);
        end
    endtask

    task automatic test_vote_send();
        run_vote(1'b1, 1'b0);
        n_vec++;
        if (dut.state !== SEND) begin
            n_err++;
            $display("FAIL reach_send: state=%0d, required %0d", dut.state, SEND);
        end
        // Waiting in SEND with rtr low must not change v_out or cts.
        tick();
        check_outs("send_wait", 4'b0000, 1'b0, 1'b0);
        // vote 1011 with sign 0000; new sign 0110
        send_and_receive("vote_green", 4'b1011, 4'b0110);
    endtask

    task automatic test_masked_resend();
        // 1011 ^ 0110 = 1101; keep sign 0110
        run_vote(1'b1, 1'b0);
        send_and_receive("masked", 4'b1101, 4'b0110);
    endtask

    task automatic test_key_drop();
        g_button = 1'b0; r_button = 1'b0;
        start = 1'b1; key = 1'b0; tick();
        key = 1'b1;              tick();
        g_button = 1'b1;         tick();  // voto1 set
        key = 1'b0;              tick();  // all vote bits cleared
        start = 1'b0;            tick();
        tick();
        g_button = 1'b0;
        // 0000 ^ 0110 = 0110; next sign 0011
        send_and_receive("key_drop", 4'b0110, 4'b0011);
    endtask

    task automatic test_both_edges();
        // voto = {0,1,1,1}; 0111 ^ 0011 = 0100; next sign 0000
        run_vote(1'b1, 1'b1);
        send_and_receive("both_edges", 4'b0100, 4'b0000);
        // red only: voto = {1,1,0,1}; 1101 ^ 0000 = 1101
        run_vote(1'b0, 1'b1);
        send_and_receive("red_only", 4'b1101, 4'b0000);
    endtask

    task automatic test_reset_mid_tx();
        // green vote with sign 0000 -> 1011, cts raised
        run_vote(1'b1, 1'b0);
        link.rtr = 1'b1;         tick();
        check_outs("pre_abort", 4'b1011, 1'b1, 1'b0);
        reset = 1'b0;            tick();
        check_outs("abort_outs", 4'b0000, 1'b0, 1'b0);
        n_vec++;
        if (dut.state !== STARTUP) begin
            n_err++;
            $display("FAIL abort_state: state=%0d, required %0d", dut.state, STARTUP);
        end
        link.rtr = 1'b0;
    endtask

    task automatic test_test_mode();
        test = 1'b1; link.v_in = 4'b1001;
        reset = 1'b1;            tick();  // STARTUP -> TEST
        check_outs("test_enter", 4'b0000, 1'b0, 1'b0);
        tick();
        check_outs("test_load", 4'b1001, 1'b0, 1'b0);
        test = 1'b0; link.v_in = 4'b0101; tick();
        check_outs("test_exit", 4'b0101, 1'b0, 1'b0);
        n_vec++;
        if (dut.state !== STANDBY) begin
            n_err++;
            $display("FAIL test_exit_state: state=%0d, required %0d", dut.state, STANDBY);
        end
        link.v_in = 4'b0000;
        // Sign loaded in test mode masks the next vote: 1011 ^ 0101 = 1110
        run_vote(1'b1, 1'b0);
        send_and_receive("test_sign", 4'b1110, 4'b0000);
    endtask

    initial begin
        test_reset();
        test_cts_mirror();
        test_vote_send();
        test_masked_resend();
        test_key_drop();
        test_both_edges();
        test_reset_mid_tx();
        test_test_mode();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
